mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Sequences the MEM pipeline stage against a multi-cycle data memory. Takes
//  the registered MEM-stage fields, runs a req/ack handshake for loads and
//  stores, holds the pipeline via stall, and presents one write-back beat per
//  instruction. Non-memory instructions pass through with 1-cycle latency.
// PARAMETERS
//  TIMEOUT  16  max BUSY cycles awaiting dmem_ack before abort (>=2)
//  CNT_W    5   width of wait counter; must hold TIMEOUT
// PORTS
//  clk            in   1   clock, rising edge
//  reset          in   1   synchronous, active-high reset
//  load           in   1   MEM-stage instruction is a load
//  store          in   1   MEM-stage instruction is a store
//  mem_address    in   32  byte address of access
//  mem_data       in   32  store data
//  reg_data       in   32  ALU result for non-memory write-back
//  write_reg      in   1   instruction writes the register file
//  reg_address    in   5   destination register
//  dmem_req       out  1   memory request, held until ack/abort
//  dmem_we        out  1   1 = write, 0 = read; valid while dmem_req
//  dmem_addr      out  32  word address, stable while dmem_req
//  dmem_wdata     out  32  write data, stable while dmem_req
//  dmem_ack       in   1   memory completion (one cycle)
//  dmem_rdata     in   32  read data, valid when dmem_ack=1
//  stall          out  1   hold IF..MEM pipeline registers (combinational)
//  wb_valid       out  1   write-back beat valid (one cycle)
//  wb_write_reg   out  1   register-file write enable for the beat
//  wb_reg_address out  5   destination register for the beat
//  wb_data        out  32  write-back data
//  access_err     out  1   one-cycle pulse: misaligned or load&store both high
//  timeout        out  1   one-cycle pulse: ack not seen within TIMEOUT cycles
// BEHAVIOUR
//  Reset: state=IDLE; every registered output 0; counter 0. Reset during BUSY
//   drops dmem_req at that edge; any later ack is ignored.
//  FSM IDLE -> BUSY -> DONE -> IDLE. All outputs except stall are registered.
//  IDLE, acc = load^store, mis = mem_address[1:0]!=0:
//   acc & !mis: latch addr/wdata/we=store, dmem_req<=1, -> BUSY.
//   (load&store) | (acc&mis): access_err<=1, wb_valid<=1, wb_write_reg<=0, stay.
//   neither: wb_valid<=1, wb_data<=reg_data, wb_write_reg<=write_reg, stay.
//  BUSY: counter++ each cycle; req/we/addr/wdata held stable.
//   dmem_ack: dmem_req<=0; wb_data<=dmem_rdata (load) / 0 (store);
//    wb_write_reg<=write_reg & load; wb_valid<=1; -> DONE.
//   counter==TIMEOUT-1 without ack: dmem_req<=0, timeout<=1, wb_valid<=1,
//    wb_write_reg<=0, -> DONE. Ack on that same cycle wins over timeout.
//  DONE: one cycle, inputs not sampled (old instruction still present); -> IDLE.
//  stall = (IDLE & acc & !mis & !(load&store)) | BUSY. Low in DONE so MEM reg
//   advances at end of DONE. Ack in IDLE/DONE ignored.
//  wb_valid/access_err/timeout are single-cycle pulses; wb_* hold otherwise.
// TESTING
//  1 no mem op, reg_data=0x1234, write_reg=1, reg_address=5 -> next cycle
//    wb_valid=1, wb_data=0x1234, wb_reg_address=5; stall never high.
//  2 load @0x100, ack 3 cycles after req with rdata 0xDEADBEEF -> req held 3
//    cycles, addr stable, stall high through BUSY, DONE beat wb_data=DEADBEEF.
//  3 store @0x200 data 0xCAFEF00D, ack first BUSY cycle -> dmem_we=1,
//    dmem_wdata=CAFEF00D, wb_write_reg=0, total stall 2 cycles.
//  4 load @0x102 -> no dmem_req, access_err pulse, wb_write_reg=0, no stall.
//  5 load, ack never (TIMEOUT=16) -> req drops after 16 BUSY cycles, timeout
//    pulse, wb_write_reg=0, return to IDLE.
//  6 reset asserted 2nd BUSY cycle, ack next cycle -> all outputs 0, ack ignored.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: runs a req/ack handshake against a multi-cycle data
// memory, stalls the pipeline while waiting, and emits one write-back beat per instruction.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        store,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_data,
  input  logic [31:0] reg_data,
  input  logic        write_reg,
  input  logic [4:0]  reg_address,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        wb_valid,
  output logic        wb_write_reg,
  output logic [4:0]  wb_reg_address,
  output logic [31:0] wb_data,
  output logic        access_err,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              req_d, we_d, wb_valid_d, wb_write_reg_d, access_err_d, timeout_d;
  logic [31:0]       addr_d, wdata_d, wb_data_d;
  logic [4:0]        wb_reg_address_d;

  logic acc, mis, both;
  assign acc  = load ^ store;
  assign mis  = |mem_address[1:0];
  assign both = load & store;

  // Only a legal access holds the pipeline from IDLE; DONE is left low so the
  // MEM register advances at the end of the write-back beat.
  assign stall = ((state == IDLE) && acc && !mis) || (state == BUSY);

  always_comb begin
    // NOTE: every next-value starts as a hold (or pulse-clear) so no path can infer a latch.
    state_d          = state;
    cnt_d            = cnt;
    req_d            = dmem_req;
    we_d             = dmem_we;
    addr_d           = dmem_addr;
    wdata_d          = dmem_wdata;
    wb_valid_d       = 1'b0;
    wb_write_reg_d   = wb_write_reg;
    wb_reg_address_d = wb_reg_address;
    wb_data_d        = wb_data;
    access_err_d     = 1'b0;
    timeout_d        = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (acc && !mis) begin
          req_d   = 1'b1;
          we_d    = store;
          addr_d  = {2'b00, mem_address[31:2]};
          wdata_d = mem_data;
          state_d = BUSY;
        end else if (both || (acc && mis)) begin
          access_err_d     = 1'b1;
          wb_valid_d       = 1'b1;
          wb_write_reg_d   = 1'b0;
          wb_reg_address_d = reg_address;
        end else begin
          wb_valid_d       = 1'b1;
          wb_data_d        = reg_data;
          wb_write_reg_d   = write_reg;
          wb_reg_address_d = reg_address;
        end
      end
      BUSY: begin
        cnt_d = cnt + 1'b1;
        // Ack is tested first so a completion on the final wait cycle still counts.
        if (dmem_ack) begin
          req_d            = 1'b0;
          wb_data_d        = dmem_we ? 32'h0 : dmem_rdata;
          wb_write_reg_d   = write_reg & load;
          wb_reg_address_d = reg_address;
          wb_valid_d       = 1'b1;
          state_d          = DONE;
        end else if (cnt == LAST_WAIT) begin
          req_d            = 1'b0;
          timeout_d        = 1'b1;
          wb_valid_d       = 1'b1;
          wb_write_reg_d   = 1'b0;
          wb_reg_address_d = reg_address;
          state_d          = DONE;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      wb_valid       <= 1'b0;
      wb_write_reg   <= 1'b0;
      wb_reg_address <= '0;
      wb_data        <= '0;
      access_err     <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      dmem_req       <= req_d;
      dmem_we        <= we_d;
      dmem_addr      <= addr_d;
      dmem_wdata     <= wdata_d;
      wb_valid       <= wb_valid_d;
      wb_write_reg   <= wb_write_reg_d;
      wb_reg_address <= wb_reg_address_d;
      wb_data        <= wb_data_d;
      access_err     <= access_err_d;
      timeout        <= timeout_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus random
// instructions checked against a transaction-level model with a word-memory array.
module tb_mem_access_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        load, store, write_reg, dmem_ack;
  logic [31:0] mem_address, mem_data, reg_data, dmem_rdata;
  logic [4:0]  reg_address;
  logic        dmem_req, dmem_we, stall, wb_valid, wb_write_reg, access_err, timeout;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [4:0]  wb_reg_address;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem_model [logic [29:0]];

  mem_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .load(load), .store(store),
    .mem_address(mem_address), .mem_data(mem_data), .reg_data(reg_data),
    .write_reg(write_reg), .reg_address(reg_address),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall),
    .wb_valid(wb_valid), .wb_write_reg(wb_write_reg), .wb_reg_address(wb_reg_address),
    .wb_data(wb_data), .access_err(access_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One instruction in the MEM stage. ack_at is the BUSY cycle index that
  // receives dmem_ack (negative or >= TIMEOUT means the memory never answers).
  task automatic run_instr(input logic ld, input logic st, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rv, input logic wr,
                           input logic [4:0] ra, input int ack_at, input string tag);
    logic        is_acc, is_err, acked;
    logic [31:0] word_addr, rdata_sent;
    is_acc    = (ld ^ st) && (addr[1:0] == 2'b00);
    is_err    = (ld & st) || ((ld ^ st) && (addr[1:0] != 2'b00));
    word_addr = addr >> 2;
    acked     = 1'b0;
    rdata_sent = 32'h0;

    load = ld; store = st; mem_address = addr; mem_data = wd; reg_data = rv;
    write_reg = wr; reg_address = ra;
    dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
    #1;
    n_cmp++; if (stall !== is_acc) begin n_bad++; $display("FAIL %s idle_stall: got %b want %b", tag, stall, is_acc); end
    tick();
    dmem_ack = 1'b0;

    if (!is_acc) begin
      n_cmp++; if ({wb_valid, access_err, dmem_req, stall} !== {1'b1, is_err, 1'b0, 1'b0}) begin
        n_bad++; $display("FAIL %s beat_flags: got v%b e%b r%b s%b want v1 e%b r0 s0", tag, wb_valid, access_err, dmem_req, stall, is_err); end
      n_cmp++; if ({wb_write_reg, wb_reg_address} !== {(is_err ? 1'b0 : wr), ra}) begin
        n_bad++; $display("FAIL %s beat_dest: got we%b rd%0d want we%b rd%0d", tag, wb_write_reg, wb_reg_address, is_err ? 1'b0 : wr, ra); end
      if (!is_err) begin
        n_cmp++; if (wb_data !== rv) begin n_bad++; $display("FAIL %s beat_data: got %h want %h", tag, wb_data, rv); end
      end
      return;
    end

    n_cmp++; if ({dmem_req, dmem_we} !== {1'b1, st}) begin n_bad++; $display("FAIL %s req_start: got req%b we%b want req1 we%b", tag, dmem_req, dmem_we, st); end
    if (st) begin
      n_cmp++; if (dmem_wdata !== wd) begin n_bad++; $display("FAIL %s wdata: got %h want %h", tag, dmem_wdata, wd); end
    end

    for (int i = 0; i < TIMEOUT; i++) begin
      n_cmp++; if ({dmem_req, stall, dmem_addr} !== {1'b1, 1'b1, word_addr}) begin
        n_bad++; $display("FAIL %s busy%0d: got req%b stall%b addr%h want req1 stall1 addr%h", tag, i, dmem_req, stall, dmem_addr, word_addr); end
      if (i == ack_at) begin
        if (!mem_model.exists(word_addr[29:0])) mem_model[word_addr[29:0]] = $urandom;
        rdata_sent = mem_model[word_addr[29:0]];
        dmem_ack = 1'b1; dmem_rdata = st ? 32'($urandom) : rdata_sent;
      end
      tick();
      dmem_ack = 1'b0; dmem_rdata = $urandom;
      if (i == ack_at) begin acked = 1'b1; break; end
    end

    if (acked && st) mem_model[word_addr[29:0]] = wd;
    n_cmp++; if ({dmem_req, stall, wb_valid, timeout} !== {1'b0, 1'b0, 1'b1, !acked}) begin
      n_bad++; $display("FAIL %s done_flags: got r%b s%b v%b t%b want r0 s0 v1 t%b", tag, dmem_req, stall, wb_valid, timeout, !acked); end
    n_cmp++; if ({wb_write_reg, wb_reg_address} !== {acked & ld & wr, ra}) begin
      n_bad++; $display("FAIL %s done_dest: got we%b rd%0d want we%b rd%0d", tag, wb_write_reg, wb_reg_address, acked & ld & wr, ra); end
    if (acked) begin
      n_cmp++; if (wb_data !== (ld ? rdata_sent : 32'h0)) begin
        n_bad++; $display("FAIL %s done_data: got %h want %h", tag, wb_data, ld ? rdata_sent : 32'h0); end
    end

    // Ack during DONE must be ignored; the machine returns to IDLE regardless.
    dmem_ack = 1'($urandom_range(0, 1));
    tick();
    dmem_ack = 1'b0;
    n_cmp++; if ({wb_valid, timeout, dmem_req, access_err} !== 4'b0000) begin
      n_bad++; $display("FAIL %s back_idle: got v%b t%b r%b e%b want 0000", tag, wb_valid, timeout, dmem_req, access_err); end
  endtask

  task automatic check_all_zero(input string tag);
    n_cmp++; if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, wb_write_reg,
                  wb_reg_address, wb_data, access_err, timeout, stall} !== '0) begin
      n_bad++; $display("FAIL %s outputs_zero: got req%b we%b a%h wd%h v%b wr%b rd%0d d%h e%b t%b s%b want all 0",
                        tag, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, wb_write_reg,
                        wb_reg_address, wb_data, access_err, timeout, stall); end
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 0; store = 0; mem_address = 0; mem_data = 0; reg_data = 0;
    write_reg = 0; reg_address = 0; dmem_ack = 0; dmem_rdata = 0;
    tick(); tick();
    check_all_zero("reset");
    reset = 1'b0;
  endtask

  task automatic test_passthrough();
    run_instr(0, 0, 32'h0000_0003, 32'h0, 32'h0000_1234, 1'b1, 5'd5, 0, "pass");
    run_instr(0, 0, 32'h0000_0040, 32'h0, 32'hA5A5_0F0F, 1'b0, 5'd31, 0, "pass_nowr");
  endtask

  task automatic test_load();
    mem_model[30'h40] = 32'hDEAD_BEEF;
    run_instr(1, 0, 32'h0000_0100, 32'h0, 32'h0, 1'b1, 5'd7, 2, "load");
  endtask

  task automatic test_store();
    run_instr(0, 1, 32'h0000_0200, 32'hCAFE_F00D, 32'h0, 1'b1, 5'd9, 0, "store");
    run_instr(1, 0, 32'h0000_0200, 32'h0, 32'h0, 1'b1, 5'd10, 1, "load_back");
  endtask

  task automatic test_errors();
    run_instr(1, 0, 32'h0000_0102, 32'h0, 32'h1, 1'b1, 5'd3, 0, "mis_load");
    run_instr(0, 1, 32'h0000_0203, 32'h5, 32'h1, 1'b1, 5'd4, 0, "mis_store");
    run_instr(1, 1, 32'h0000_0300, 32'h5, 32'h1, 1'b1, 5'd6, 0, "load_store");
  endtask

  task automatic test_timeout();
    run_instr(1, 0, 32'h0000_0400, 32'h0, 32'h0, 1'b1, 5'd11, -1, "timeout");
    run_instr(1, 0, 32'h0000_0404, 32'h0, 32'h0, 1'b1, 5'd12, TIMEOUT - 1, "ack_last");
  endtask

  task automatic test_reset_busy();
    run_instr(0, 0, 32'h0, 32'h0, 32'h7777_7777, 1'b1, 5'd13, 0, "pre_reset");
    load = 1; store = 0; mem_address = 32'h0000_0500; write_reg = 1; reg_address = 5'd14;
    tick(); tick();
    reset = 1'b1; load = 0; mem_address = 0; reg_data = 0; write_reg = 0; reg_address = 0;
    tick();
    check_all_zero("reset_busy");
    reset = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    tick();
    dmem_ack = 1'b0;
    n_cmp++; if ({dmem_req, stall, timeout, wb_write_reg, wb_data} !== {4'b0000, 32'h0}) begin
      n_bad++; $display("FAIL late_ack: got r%b s%b t%b wr%b d%h want r0 s0 t0 wr0 d0", dmem_req, stall, timeout, wb_write_reg, wb_data); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic        ld, st;
      logic [31:0] addr;
      int          ack_at;
      int          kind = $urandom_range(0, 9);
      ld = (kind < 4) || (kind == 9);
      st = (kind >= 4 && kind < 7) || (kind == 9);
      addr = 32'h1000 + 4 * $urandom_range(0, 7);
      if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      ack_at = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 5);
      run_instr(ld, st, addr, $urandom, $urandom, 1'($urandom), 5'($urandom), ack_at, "rand");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_load();
    test_store();
    test_errors();
    test_timeout();
    test_reset_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
